bulls_cows_controller: RTL and testbench

- Game-control FSM for the two-player Bulls and Cows game.
- Captures each player's 4-digit secret from the switches, then alternates guesses between the players.
- Computes bull and cow counts for each guess, and keeps per-player win points.
- Sits directly upstream of the 7-segment/LED display driver and drives all of its game inputs: game_state, guess_confirmed, bull_count, cow_count, J1_points, J2_points.

---
 rtl/bulls_cows_controller_if.sv | 41 ++++
 rtl/bulls_cows_controller.sv | 157 +++++++++++++++
 tb/tb_bulls_cows_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/bulls_cows_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : bulls_cows_controller_if
// Description : Switch/enter inputs and display-facing game outputs of the
//               Bulls and Cows controller. Optional macro: ENTRY_ERROR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface bulls_cows_controller_if #(
    parameter int POINTS_W = 8
);
    logic [15:0]         SW;
    logic                enter;
    logic [2:0]          game_state;
    logic                guess_confirmed;
    logic [2:0]          bull_count;
    logic [2:0]          cow_count;
    logic [POINTS_W-1:0] J1_points;
    logic [POINTS_W-1:0] J2_points;
`ifdef ENTRY_ERROR_EN
    logic                entry_error;
`endif

    // Controller side
    modport master (
        input  SW, enter,
        output game_state, guess_confirmed, bull_count, cow_count, J1_points, J2_points
`ifdef ENTRY_ERROR_EN
        , output entry_error
`endif
    );

    // Switch/display side
    modport slave (
        output SW, enter,
        input  game_state, guess_confirmed, bull_count, cow_count, J1_points, J2_points
`ifdef ENTRY_ERROR_EN
        , input entry_error
`endif
    );
endinterface
`default_nettype wire

// File: rtl/bulls_cows_controller.sv
`default_nettype none
// ============================================================================
// Module      : bulls_cows_controller
// Description : Two-player Bulls and Cows game FSM with bull/cow scoring and
//               saturating win points. Optional macro: ENTRY_ERROR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bulls_cows_controller #(
    parameter int MAX_DIGIT = 9,
    parameter int POINTS_W  = 8
) (
    input  wire logic               clock,
    input  wire logic               reset,
    bulls_cows_controller_if.master bus
);

    localparam logic [2:0] c_J1_SETUP  = 3'b000;
    localparam logic [2:0] c_J2_SETUP  = 3'b001;
    localparam logic [2:0] c_J1_GUESS  = 3'b010;
    localparam logic [2:0] c_J2_GUESS  = 3'b011;
    localparam logic [2:0] c_END_GAME  = 3'b111;
    localparam logic [3:0] c_MAX_DIGIT = 4'(MAX_DIGIT);

    logic [2:0]          r_state;
    logic                r_confirmed;
    logic [2:0]          r_bull;
    logic [2:0]          r_cow;
    logic [POINTS_W-1:0] r_j1_points;
    logic [POINTS_W-1:0] r_j2_points;
    logic [15:0]         r_secret1;
    logic [15:0]         r_secret2;

    logic [15:0]         w_opp_secret;
    logic                w_valid;
    logic [2:0]          w_bull;
    logic [2:0]          w_cow;

    function automatic logic [3:0] digit(input logic [15:0] v, input int idx);
        return v[15-4*idx -: 4];
    endfunction

    // Validity and scoring of the current switch value against the opponent's secret
    always_comb begin
        w_opp_secret = (r_state == c_J1_GUESS) ? r_secret2 : r_secret1;
        w_valid      = 1'b1;
        w_bull       = '0;
        w_cow        = '0;
        for (int i = 0; i < 4; i++) begin
            if (digit(bus.SW, i) > c_MAX_DIGIT)
                w_valid = 1'b0;
            if (digit(bus.SW, i) == digit(w_opp_secret, i))
                w_bull = w_bull + 3'd1;
            for (int j = 0; j < 4; j++) begin
                if (i != j) begin
                    if (digit(bus.SW, i) == digit(bus.SW, j))
                        w_valid = 1'b0;
                    if (digit(bus.SW, i) == digit(w_opp_secret, j))
                        w_cow = w_cow + 3'd1;
                end
            end
        end
    end

`ifdef ENTRY_ERROR_EN
    logic r_entry_error;
    logic w_reject;

    // Phase B and END_GAME consume enter without validating SW
    always_comb begin
        w_reject = 1'b0;
        if (bus.enter && !w_valid) begin
            case (r_state)
                c_J1_SETUP, c_J2_SETUP: w_reject = 1'b1;
                c_J1_GUESS, c_J2_GUESS: w_reject = !r_confirmed;
                default:                w_reject = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_entry_error <= 1'b0;
        else        r_entry_error <= w_reject;
    end

    assign bus.entry_error = r_entry_error;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_J1_SETUP;
            r_confirmed <= 1'b0;
            r_bull      <= '0;
            r_cow       <= '0;
            r_j1_points <= '0;
            r_j2_points <= '0;
            r_secret1   <= '0;
            r_secret2   <= '0;
        end else begin
            case (r_state)
                c_J1_SETUP: begin
                    if (bus.enter && w_valid) begin
                        r_secret1 <= bus.SW;
                        r_state   <= c_J2_SETUP;
                    end
                end
                c_J2_SETUP: begin
                    if (bus.enter && w_valid) begin
                        r_secret2 <= bus.SW;
                        r_state   <= c_J1_GUESS;
                        r_bull    <= '0;
                        r_cow     <= '0;
                    end
                end
                c_J1_GUESS, c_J2_GUESS: begin
                    if (bus.enter) begin
                        if (r_confirmed) begin
                            r_confirmed <= 1'b0;
                            r_state     <= (r_state == c_J1_GUESS) ? c_J2_GUESS : c_J1_GUESS;
                        end else if (w_valid) begin
                            r_bull <= w_bull;
                            r_cow  <= w_cow;
                            if (w_bull == 3'd4) begin
                                r_state <= c_END_GAME;
                                if (r_state == c_J1_GUESS) begin
                                    if (r_j1_points != '1)
                                        r_j1_points <= r_j1_points + POINTS_W'(1);
                                end else begin
                                    if (r_j2_points != '1)
                                        r_j2_points <= r_j2_points + POINTS_W'(1);
                                end
                            end else begin
                                r_confirmed <= 1'b1;
                            end
                        end
                    end
                end
                c_END_GAME: begin
                    if (bus.enter) begin
                        r_state <= c_J1_SETUP;
                        r_bull  <= '0;
                        r_cow   <= '0;
                    end
                end
                default: r_state <= c_J1_SETUP;
            endcase
        end
    end

    assign bus.game_state      = r_state;
    assign bus.guess_confirmed = r_confirmed;
    assign bus.bull_count      = r_bull;
    assign bus.cow_count       = r_cow;
    assign bus.J1_points       = r_j1_points;
    assign bus.J2_points       = r_j2_points;

endmodule
`default_nettype wire

// File: tb/tb_bulls_cows_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bulls_cows_controller
// Description : Directed plus randomized bench for bulls_cows_controller,
//               scored against a rule-level game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bulls_cows_controller;

    localparam int POINTS_W = 2;
    localparam int PTS_MAX  = (1 << POINTS_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;

    bulls_cows_controller_if #(.POINTS_W(POINTS_W)) bus ();

    bulls_cows_controller #(.MAX_DIGIT(9), .POINTS_W(POINTS_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Game model: stage 0=P1 secret entry, 1=P2 secret entry, 2=guessing, 3=round over
    int          m_stage, m_player, m_conf, m_bull, m_cow, m_err;
    int          m_pts [2];
    logic [15:0] m_sec [2];

    function automatic int dig(input logic [15:0] v, input int i);
        return int'((v >> (12 - 4*i)) & 16'hF);
    endfunction

    function automatic bit legal(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            if (dig(v, i) > 9) return 1'b0;
            for (int j = i + 1; j < 4; j++)
                if (dig(v, i) == dig(v, j)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int exp_state();
        case (m_stage)
            0:       return 0;
            1:       return 1;
            2:       return (m_player == 1) ? 2 : 3;
            default: return 7;
        endcase
    endfunction

    task automatic model_reset();
        m_stage = 0; m_player = 1; m_conf = 0; m_bull = 0; m_cow = 0; m_err = 0;
        m_pts[0] = 0; m_pts[1] = 0; m_sec[0] = '0; m_sec[1] = '0;
    endtask

    task automatic model_enter(input logic [15:0] sw);
        bit ok;
        logic [15:0] s;
        ok    = legal(sw);
        m_err = 0;
        case (m_stage)
            0: if (ok) begin m_sec[0] = sw; m_stage = 1; end else m_err = 1;
            1: if (ok) begin m_sec[1] = sw; m_stage = 2; m_player = 1; m_bull = 0; m_cow = 0; end
               else m_err = 1;
            2: begin
                if (m_conf != 0) begin
                    m_conf = 0;
                    m_player = 3 - m_player;
                end else if (ok) begin
                    s = m_sec[2 - m_player];
                    m_bull = 0; m_cow = 0;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            if (dig(sw, i) == dig(s, j)) begin
                                if (i == j) m_bull++; else m_cow++;
                            end
                    if (m_bull == 4) begin
                        m_stage = 3;
                        if (m_pts[m_player-1] < PTS_MAX) m_pts[m_player-1]++;
                    end else m_conf = 1;
                end else m_err = 1;
            end
            default: begin m_stage = 0; m_bull = 0; m_cow = 0; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input int exp_v);
        n_vec++;
        assert (obs === 16'(exp_v))
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("game_state", 16'(bus.game_state), exp_state());
        chk("guess_confirmed", 16'(bus.guess_confirmed), m_conf);
        chk("bull_count", 16'(bus.bull_count), m_bull);
        chk("cow_count", 16'(bus.cow_count), m_cow);
        chk("J1_points", 16'(bus.J1_points), m_pts[0]);
        chk("J2_points", 16'(bus.J2_points), m_pts[1]);
`ifdef ENTRY_ERROR_EN
        chk("entry_error", 16'(bus.entry_error), m_err);
`endif
    endtask

    // Called at a negedge; returns at a negedge two cycles later
    task automatic press(input logic [15:0] sw);
        bus.SW    = sw;
        bus.enter = 1'b1;
        @(posedge clock);
        model_enter(sw);
        @(negedge clock);
        bus.enter = 1'b0;
        check_all();
        m_err = 0;
        @(negedge clock);
        check_all();
    endtask

    // Asynchronous reset with a coincident enter held across an edge
    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        bus.SW    = 16'h9876;
        bus.enter = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_all();
        bus.enter = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
    endtask

    function automatic logic [15:0] rand_legal();
        int a [10];
        int k, t;
        for (int i = 0; i < 10; i++) a[i] = i;
        for (int i = 9; i > 0; i--) begin
            k = int'($urandom_range(i, 0));
            t = a[i]; a[i] = a[k]; a[k] = t;
        end
        return {a[0][3:0], a[1][3:0], a[2][3:0], a[3][3:0]};
    endfunction

    function automatic logic [15:0] rand_entry();
        int r;
        r = int'($urandom_range(99, 0));
        if (m_stage == 2 && m_conf == 0 && r < 25) return m_sec[2 - m_player];
        if (r < 75) return rand_legal();
        return 16'($urandom());
    endfunction

    initial begin
        bus.SW    = '0;
        bus.enter = 1'b0;
        @(negedge clock);
        apply_reset();

        // Setup with invalid attempts
        press(16'h1123);
        press(16'h12A4);
        press(16'h1234);
        press(16'h5678);
        // J1 guess, handover, J2 win, new round
        press(16'h5687);
        press(16'h0000);
        press(16'h1234);
        press(16'h0000);

        // J1 wins four rounds to saturate its counter
        for (int r = 0; r < 4; r++) begin
            press(16'h1234);
            press(16'h5678);
            press(16'h5678);
            press(16'h0000);
        end

        // Reset during J2 phase B with J1 at two points
        @(negedge clock);
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            press(16'h1234); press(16'h5678); press(16'h5678); press(16'h0000);
        end
        press(16'h1234);
        press(16'h5678);
        press(16'h0987);
        press(16'hFFFF);
        press(16'h4321);
        chk("pre_reset_J1_points", 16'(bus.J1_points), 2);
        apply_reset();

        // Randomized play
        for (int n = 0; n < 300; n++)
            press(rand_entry());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
